// File: rtl/zbt_pix_arbiter_pkg.sv
// zbt_pix_arbiter_pkg: shared widths, defaults and grant-source encoding for the ZBT pixel arbiter
package zbt_pix_arbiter_pkg;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 36;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int RD_LAT_DEF = 2;
    localparam int STARVE_MAX_DEF = 8;
    typedef enum logic [1:0] {SRC_IDLE, SRC_DISP, SRC_CAM, SRC_PROC} src_e;
endpackage

// File: rtl/zbt_pix_arbiter_if.sv
// zbt_pix_if: requester and ZBT pin bundle shared by the arbiter and its environment
interface zbt_pix_if;
    import zbt_pix_arbiter_pkg::*;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_grant;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              cam_we;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic              cam_full;
    logic              proc_we;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_data;
    logic              proc_full;
    logic              clr_ovf;
    logic              cam_ovf;
    logic              proc_ovf;
    logic              zbt_we;
    logic [ADDR_W-1:0] zbt_addr;
    logic [DATA_W-1:0] zbt_wdata;
    logic [DATA_W-1:0] zbt_rdata;
    modport slave (
        input  disp_req, disp_addr, cam_we, cam_addr, cam_data, proc_we, proc_addr, proc_data,
               clr_ovf, zbt_rdata,
        output disp_grant, disp_data, disp_valid, cam_full, proc_full, cam_ovf, proc_ovf,
               zbt_we, zbt_addr, zbt_wdata
    );
    modport master (
        output disp_req, disp_addr, cam_we, cam_addr, cam_data, proc_we, proc_addr, proc_data,
               clr_ovf, zbt_rdata,
        input  disp_grant, disp_data, disp_valid, cam_full, proc_full, cam_ovf, proc_ovf,
               zbt_we, zbt_addr, zbt_wdata
    );
endinterface

// File: rtl/zbt_pix_arbiter_fifo.sv
// pix_wr_fifo: write-stream FIFO with registered head, no fall-through and sticky drop flag
module pix_wr_fifo #(
    parameter int W = 55,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    input  logic         clr_ovf_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o,
    output logic         ovf_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d, push, pop;
    always_comb begin
        full_o = cnt_q == (AW+1)'(DEPTH);
        empty_o = cnt_q == '0;
        push = we_i && !full_o;
        pop = pop_i && !empty_o;
        wp_d = wp_q + AW'(push);
        rp_d = rp_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d = (we_i && full_o) || (ovf_q && !clr_ovf_i);
    end
    assign head_o = mem[rp_q];
    assign ovf_o = ovf_q;
    always_ff @(posedge clk) if (push) mem[wp_q] <= din_i;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: rtl/zbt_pix_arbiter.sv
// zbt_pix_arbiter: one ZBT op per clk, display first, with a starvation guard for buffered writes
module zbt_pix_arbiter
    import zbt_pix_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic      clk,
    input logic      reset,
    zbt_pix_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int W = ADDR_W + DATA_W;
    logic cam_full, cam_empty, proc_full, proc_empty, any_wr, both_wr, is_wr;
    logic [W-1:0] cam_head, proc_head, wr_head;
    src_e src, wr_src, rr_q, rr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, data_q, data_d;
    logic [RD_LAT+1:0] vp_q, vp_d;
    pix_wr_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_cam (
        .clk(clk), .reset(reset), .we_i(bus.cam_we), .din_i({bus.cam_addr, bus.cam_data}),
        .pop_i(src == SRC_CAM), .clr_ovf_i(bus.clr_ovf), .full_o(cam_full),
        .empty_o(cam_empty), .head_o(cam_head), .ovf_o(bus.cam_ovf)
    );
    pix_wr_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_proc (
        .clk(clk), .reset(reset), .we_i(bus.proc_we), .din_i({bus.proc_addr, bus.proc_data}),
        .pop_i(src == SRC_PROC), .clr_ovf_i(bus.clr_ovf), .full_o(proc_full),
        .empty_o(proc_empty), .head_o(proc_head), .ovf_o(bus.proc_ovf)
    );
    always_comb begin
        any_wr = !cam_empty || !proc_empty;
        both_wr = !cam_empty && !proc_empty;
        wr_src = both_wr ? (rr_q == SRC_CAM ? SRC_PROC : SRC_CAM) : (cam_empty ? SRC_PROC : SRC_CAM);
        src = !any_wr ? (bus.disp_req ? SRC_DISP : SRC_IDLE) :
              (starve_q == SW'(STARVE_MAX) || !bus.disp_req) ? wr_src : SRC_DISP;
        is_wr = src == SRC_CAM || src == SRC_PROC;
        wr_head = src == SRC_CAM ? cam_head : proc_head;
        rr_d = is_wr ? src : rr_q;
        starve_d = (is_wr || !any_wr) ? '0 :
                   (src == SRC_DISP && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
        we_d = is_wr;
        addr_d = src == SRC_DISP ? bus.disp_addr : is_wr ? wr_head[W-1:DATA_W] : addr_q;
        wdata_d = is_wr ? wr_head[DATA_W-1:0] : wdata_q;
        // stage RD_LAT lines up with zbt_rdata for the address issued at stage 0
        vp_d = {vp_q[RD_LAT:0], src == SRC_DISP};
        data_d = vp_q[RD_LAT] ? bus.zbt_rdata : data_q;
    end
    assign bus.disp_grant = src == SRC_DISP;
    assign bus.disp_valid = vp_q[RD_LAT+1];
    assign bus.disp_data = data_q;
    assign bus.cam_full = cam_full;
    assign bus.proc_full = proc_full;
    assign bus.zbt_we = we_q;
    assign bus.zbt_addr = addr_q;
    assign bus.zbt_wdata = wdata_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= SRC_PROC;
            starve_q <= '0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            data_q <= '0;
            vp_q <= '0;
        end else begin
            rr_q <= rr_d;
            starve_q <= starve_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            data_q <= data_d;
            vp_q <= vp_d;
        end
    end
endmodule

// File: tb/tb_zbt_pix_arbiter.sv
// tb_zbt_pix_arbiter: directed stimulus with queued expectations checked by a negedge monitor
module tb_zbt_pix_arbiter;
    import zbt_pix_arbiter_pkg::*;
    typedef struct packed {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0, n_pass = 0, cyc = 0, n_we = 0, n_val = 0, w2cnt = 0;
    wr_t wq[$];
    logic [DATA_W-1:0] rq[$];
    int wcyc[$], vcyc[$], gcyc[$];
    wr_t e;
    logic [DATA_W-1:0] r1;
    always #5 clk = ~clk;
    zbt_pix_if bus();
    zbt_pix_if bus2();
    zbt_pix_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
    zbt_pix_arbiter #(.STARVE_MAX(64)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    assign bus2.zbt_rdata = '0;

    function automatic logic [DATA_W-1:0] f(input logic [ADDR_W-1:0] a);
        return {17'h1A5A5, a} ^ 36'h0F0F0F0F0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        int n = 0;
        logic g = 1'b0;
        bus.disp_req = 1'b1;
        bus.disp_addr = a;
        rq.push_back(f(a));
        while (!g && n < 40) begin
            @(negedge clk);
            g = bus.disp_grant;
            tick();
            n++;
        end
        chk("disp grant", 64'(g), 1);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        r1 <= f(bus.zbt_addr);
        bus.zbt_rdata <= r1;
    end

    always @(negedge clk) if (!reset) begin
        if (bus.disp_grant) gcyc.push_back(cyc);
        if (bus.zbt_we) begin
            n_we++;
            wcyc.push_back(cyc);
            chk("expected write pending", 64'(wq.size() != 0), 1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("zbt_addr", 64'(bus.zbt_addr), 64'(e.a));
                chk("zbt_wdata", 64'(bus.zbt_wdata), 64'(e.d));
            end
        end
        if (bus.disp_valid) begin
            n_val++;
            vcyc.push_back(cyc);
            chk("expected read pending", 64'(rq.size() != 0), 1);
            if (rq.size() != 0) chk("disp_data", 64'(bus.disp_data), 64'(rq.pop_front()));
        end
    end

    always @(negedge clk) if (!reset && bus2.zbt_we) w2cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int nw, nv;
        {bus.disp_req, bus.disp_addr, bus.cam_we, bus.cam_addr, bus.cam_data} = '0;
        {bus.proc_we, bus.proc_addr, bus.proc_data, bus.clr_ovf} = '0;
        {bus2.disp_req, bus2.disp_addr, bus2.cam_we, bus2.cam_addr, bus2.cam_data} = '0;
        {bus2.proc_we, bus2.proc_addr, bus2.proc_data, bus2.clr_ovf} = '0;
        tick(3);
        chk("reset zbt_we", 64'(bus.zbt_we), 0);
        chk("reset zbt_addr", 64'(bus.zbt_addr), 0);
        chk("reset zbt_wdata", 64'(bus.zbt_wdata), 0);
        chk("reset disp_valid", 64'(bus.disp_valid), 0);
        chk("reset disp_data", 64'(bus.disp_data), 0);
        chk("reset full flags", 64'({bus.cam_full, bus.proc_full}), 0);
        chk("reset ovf flags", 64'({bus.cam_ovf, bus.proc_ovf}), 0);
        chk("reset disp_grant", 64'(bus.disp_grant), 0);
        reset = 1'b0;
        tick(2);

        wcyc.delete();
        for (int i = 0; i < 3; i++) begin
            bus.cam_we = 1'b1;
            bus.cam_addr = 19'h00010 + 19'(i);
            bus.cam_data = 36'hC00000000 + 36'(i);
            wq.push_back({bus.cam_addr, bus.cam_data});
            tick();
        end
        bus.cam_we = 1'b0;
        tick(8);
        chk("cam write count", 64'(wcyc.size()), 3);
        chk("cam writes consecutive", 64'(wcyc.size() == 3 ? wcyc[2] - wcyc[0] : -1), 2);
        chk("cam queue drained", 64'(wq.size()), 0);

        gcyc.delete();
        vcyc.delete();
        for (int i = 0; i < 5; i++) rd(19'h00100 + 19'(i));
        bus.disp_req = 1'b0;
        tick(10);
        chk("read return count", 64'(vcyc.size()), 5);
        chk("first read latency", 64'(vcyc.size() > 0 && gcyc.size() > 0 ? vcyc[0] - gcyc[0] : -1), 4);
        chk("back-to-back valid", 64'(vcyc.size() == 5 ? vcyc[4] - vcyc[0] : -1), 4);

        gcyc.delete();
        wcyc.delete();
        bus.proc_we = 1'b1;
        bus.proc_addr = 19'h0003A;
        bus.proc_data = 36'hABCDE1234;
        wq.push_back({bus.proc_addr, bus.proc_data});
        tick();
        bus.proc_we = 1'b0;
        for (int i = 0; i < 12; i++) rd(19'h00200 + 19'(i));
        bus.disp_req = 1'b0;
        tick(10);
        chk("starve grant count", 64'(gcyc.size()), 12);
        chk("eight display grants", 64'(gcyc.size() > 7 ? gcyc[7] - gcyc[0] : -1), 7);
        chk("forced write gap", 64'(gcyc.size() > 8 ? gcyc[8] - gcyc[7] : -1), 2);
        chk("forced write slot", 64'(wcyc.size() == 1 && gcyc.size() > 7 ? wcyc[0] - gcyc[7] : -1), 2);
        chk("display resumes", 64'(gcyc.size() == 12 ? gcyc[11] - gcyc[8] : -1), 3);

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        wcyc.delete();
        for (int i = 0; i < 4; i++) begin
            bus.cam_we = 1'b1;
            bus.cam_addr = 19'h01000 + 19'(i);
            bus.cam_data = 36'h111110000 + 36'(i);
            bus.proc_we = 1'b1;
            bus.proc_addr = 19'h02000 + 19'(i);
            bus.proc_data = 36'h222220000 + 36'(i);
            wq.push_back({bus.cam_addr, bus.cam_data});
            wq.push_back({bus.proc_addr, bus.proc_data});
            tick();
        end
        {bus.cam_we, bus.proc_we} = '0;
        tick(12);
        chk("rr write count", 64'(wcyc.size()), 8);
        chk("rr writes consecutive", 64'(wcyc.size() == 8 ? wcyc[7] - wcyc[0] : -1), 7);

        bus2.disp_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus2.proc_we = 1'b1;
            bus2.proc_addr = 19'h00040 + 19'(i);
            bus2.proc_data = 36'h333330000 + 36'(i);
            tick();
            if (i == 15) begin
                chk("proc_full at 16", 64'(bus2.proc_full), 1);
                chk("proc_ovf before drop", 64'(bus2.proc_ovf), 0);
            end
        end
        bus2.proc_we = 1'b0;
        chk("proc_ovf after drop", 64'(bus2.proc_ovf), 1);
        bus2.proc_we = 1'b1;
        bus2.clr_ovf = 1'b1;
        tick();
        {bus2.proc_we, bus2.clr_ovf} = '0;
        chk("ovf kept on clr with drop", 64'(bus2.proc_ovf), 1);
        bus2.disp_req = 1'b0;
        tick(25);
        chk("proc stored count", 64'(w2cnt), 16);
        chk("proc_full after drain", 64'(bus2.proc_full), 0);
        chk("proc_ovf sticky", 64'(bus2.proc_ovf), 1);
        bus2.clr_ovf = 1'b1;
        tick();
        bus2.clr_ovf = 1'b0;
        chk("proc_ovf cleared", 64'(bus2.proc_ovf), 0);

        nw = n_we;
        nv = n_val;
        bus.disp_req = 1'b1;
        bus.disp_addr = 19'h00300;
        for (int i = 0; i < 3; i++) begin
            bus.cam_we = 1'b1;
            bus.cam_addr = 19'h04000 + 19'(i);
            bus.proc_we = i < 2;
            bus.proc_addr = 19'h05000 + 19'(i);
            tick();
        end
        reset = 1'b1;
        {bus.disp_req, bus.cam_we, bus.proc_we} = '0;
        tick(2);
        reset = 1'b0;
        tick(15);
        chk("no zbt_we after reset", 64'(n_we - nw), 0);
        chk("no disp_valid after reset", 64'(n_val - nv), 0);
        bus.cam_we = 1'b1;
        bus.cam_addr = 19'h06000;
        bus.cam_data = 36'h444444444;
        wq.push_back({bus.cam_addr, bus.cam_data});
        tick();
        bus.cam_we = 1'b0;
        tick(5);
        chk("new write after reset", 64'(n_we - nw), 1);
        chk("write scoreboard empty", 64'(wq.size()), 0);
        chk("read scoreboard empty", 64'(rq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
